// File: rtl/cnn_pkg.sv
// Shared CNN definitions: pooling FSM state encoding, pooling mode
// constants, default pixel width and the pixel typedef used across the
// CNN blocks.
package cnn_pkg;

    localparam int CNN_DATA_W = 16;

    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;

    typedef shortint pixel_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_REDUCE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE
    } pool_state_e;

endpackage

// File: rtl/pool_window_reduce.sv
// Combinational reduction of one WIN x WIN window of signed pixels.
//   win_i    : WIN*WIN pixels, row-major, element 0 in the LSBs
//   mode_i   : POOL_MAX = signed maximum, POOL_AVG = floor of the mean
//   result_o : reduced pixel
// The average keeps the full sum in DATA_W + 2*log2(WIN) bits and divides
// with an arithmetic shift, so rounding is toward minus infinity.
module pool_window_reduce
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int WIN    = 2
) (
    input  logic [WIN*WIN*DATA_W-1:0] win_i,
    input  logic                      mode_i,
    output logic [DATA_W-1:0]         result_o
);

    localparam int N     = WIN * WIN;
    localparam int SH    = 2 * $clog2(WIN);
    localparam int SUM_W = DATA_W + SH;

    logic signed [DATA_W-1:0] elem;
    logic signed [DATA_W-1:0] max_v;
    logic signed [SUM_W-1:0]  sum_v;

    always_comb begin
        max_v = win_i[DATA_W-1:0];
        sum_v = '0;
        elem  = '0;
        for (int i = 0; i < N; i++) begin
            elem = win_i[i*DATA_W +: DATA_W];
            if (elem > max_v) max_v = elem;
            sum_v = sum_v + SUM_W'(elem);
        end
        if (mode_i == POOL_AVG) result_o = DATA_W'(sum_v >>> SH);
        else                    result_o = max_v;
    end

endmodule

// File: rtl/pool_layer_sequencer.sv
// Pooling-layer controller. Walks channel / oy / ox over the output map,
// requests each WINxWIN input window from the DMA, reduces it and issues a
// one-word write-back to a contiguous destination range.
//   clk, reset           : clock, synchronous active-high reset
//   start / busy / finish: launch level, run indicator, done indicator
//   cfg_*                : layer geometry, base addresses, pool mode
//   rd_req/addr/offset   : window read request (top-left word, row pitch)
//   rd_done/rd_data      : window returned
//   wr_req/addr/data     : result write request
//   wr_done              : write complete
// Handshake: a request is a one-cycle pulse; its address/data stay stable
// until the matching done pulse, and done is only honoured in the WAIT state
// that follows that request.
module pool_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int DATA_W   = CNN_DATA_W,
    parameter int ADDR_W   = 16,
    parameter int WIN      = 2,
    parameter int STRIDE   = 2,
    parameter int MAX_CH   = 128,
    parameter int MAX_SIZE = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [$clog2(MAX_CH+1)-1:0]       cfg_channels,
    input  logic [$clog2(MAX_SIZE+1)-1:0]     cfg_size,
    input  logic [ADDR_W-1:0]                 cfg_src_base,
    input  logic [ADDR_W-1:0]                 cfg_dst_base,
    input  logic                              cfg_mode,
    output logic                              rd_req,
    output logic [ADDR_W-1:0]                 rd_addr,
    output logic [ADDR_W-1:0]                 rd_offset,
    input  logic                              rd_done,
    input  logic [WIN*WIN*DATA_W-1:0]         rd_data,
    output logic                              wr_req,
    output logic [ADDR_W-1:0]                 wr_addr,
    output logic [DATA_W-1:0]                 wr_data,
    input  logic                              wr_done,
    output logic                              busy,
    output logic                              finish
);

    localparam int CH_W = $clog2(MAX_CH + 1);
    localparam int SZ_W = $clog2(MAX_SIZE + 1);

    pool_state_e state_q, state_d;

    // Latched layer configuration and derived geometry
    logic [CH_W-1:0]   chans_q;
    logic [SZ_W-1:0]   size_q;
    logic [SZ_W-1:0]   out_last_q;   // out_size - 1
    logic              mode_q;
    logic [ADDR_W-1:0] plane_q;      // size^2, channel step
    logic [ADDR_W-1:0] row_step_q;   // STRIDE * size, output-row step

    // Pixel walk; addresses are tracked incrementally so no multiplier is
    // needed. ch_base/row_base are the window addresses at ox=0 (and oy=0).
    logic [CH_W-1:0]   c_q;
    logic [SZ_W-1:0]   oy_q, ox_q;
    logic [ADDR_W-1:0] ch_base_q, row_base_q, pix_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;

    logic [WIN*WIN*DATA_W-1:0] win_q;
    logic [DATA_W-1:0]         wr_data_q;
    logic [DATA_W-1:0]         red_result;
    logic                      last_pix;
    logic                      degenerate;

    assign degenerate = (cfg_channels == '0) || (int'(cfg_size) < WIN);
    assign last_pix   = (c_q == chans_q - CH_W'(1)) &&
                        (oy_q == out_last_q) && (ox_q == out_last_q);

    pool_window_reduce #(
        .DATA_W (DATA_W),
        .WIN    (WIN)
    ) u_reduce (
        .win_i    (win_q),
        .mode_i   (mode_q),
        .result_o (red_result)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start) state_d = degenerate ? ST_DONE : ST_RD_REQ;
            ST_RD_REQ:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: if (rd_done) state_d = ST_REDUCE;
            ST_REDUCE:  state_d = ST_WR_REQ;
            ST_WR_REQ:  state_d = ST_WR_WAIT;
            ST_WR_WAIT: if (wr_done) state_d = last_pix ? ST_DONE : ST_RD_REQ;
            ST_DONE:    if (!start) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        rd_req = (state_q == ST_RD_REQ);
        wr_req = (state_q == ST_WR_REQ);
        finish = (state_q == ST_DONE);
        busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    end

    assign rd_addr   = pix_addr_q;
    assign rd_offset = ADDR_W'(size_q);
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

    // Datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            chans_q    <= '0;
            size_q     <= '0;
            out_last_q <= '0;
            mode_q     <= POOL_MAX;
            plane_q    <= '0;
            row_step_q <= '0;
            c_q        <= '0;
            oy_q       <= '0;
            ox_q       <= '0;
            ch_base_q  <= '0;
            row_base_q <= '0;
            pix_addr_q <= '0;
            wr_addr_q  <= '0;
            win_q      <= '0;
            wr_data_q  <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: if (start) begin
                    chans_q    <= cfg_channels;
                    size_q     <= cfg_size;
                    // Only meaningful when size >= WIN; otherwise the run
                    // goes straight to DONE and never uses it.
                    out_last_q <= SZ_W'((int'(cfg_size) - WIN) / STRIDE);
                    mode_q     <= cfg_mode;
                    plane_q    <= ADDR_W'(int'(cfg_size) * int'(cfg_size));
                    row_step_q <= ADDR_W'(STRIDE * int'(cfg_size));
                    c_q        <= '0;
                    oy_q       <= '0;
                    ox_q       <= '0;
                    ch_base_q  <= cfg_src_base;
                    row_base_q <= cfg_src_base;
                    pix_addr_q <= cfg_src_base;
                    wr_addr_q  <= cfg_dst_base;
                end
                ST_RD_WAIT: if (rd_done) win_q <= rd_data;
                ST_REDUCE:  wr_data_q <= red_result;
                ST_WR_WAIT: if (wr_done) begin
                    wr_addr_q <= wr_addr_q + ADDR_W'(1);
                    if (ox_q != out_last_q) begin
                        ox_q       <= ox_q + SZ_W'(1);
                        pix_addr_q <= pix_addr_q + ADDR_W'(STRIDE);
                    end else if (oy_q != out_last_q) begin
                        ox_q       <= '0;
                        oy_q       <= oy_q + SZ_W'(1);
                        row_base_q <= row_base_q + row_step_q;
                        pix_addr_q <= row_base_q + row_step_q;
                    end else begin
                        ox_q       <= '0;
                        oy_q       <= '0;
                        c_q        <= c_q + CH_W'(1);
                        ch_base_q  <= ch_base_q + plane_q;
                        row_base_q <= ch_base_q + plane_q;
                        pix_addr_q <= ch_base_q + plane_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_layer_sequencer.sv
// Directed bench for pool_layer_sequencer (WIN=2, STRIDE=2, 16-bit words).
// A responder models the DMA from a word memory; expected reads and writes
// are queued before each run and popped by a monitor on every request.
module tb_pool_layer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  cfg_channels;
    logic [5:0]  cfg_size;
    logic [15:0] cfg_src_base, cfg_dst_base;
    logic        cfg_mode;
    logic        rd_req;
    logic [15:0] rd_addr, rd_offset;
    logic        rd_done;
    logic [63:0] rd_data;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_done;
    logic        busy, finish;

    pool_layer_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cfg_channels (cfg_channels),
        .cfg_size     (cfg_size),
        .cfg_src_base (cfg_src_base),
        .cfg_dst_base (cfg_dst_base),
        .cfg_mode     (cfg_mode),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_offset    (rd_offset),
        .rd_done      (rd_done),
        .rd_data      (rd_data),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_done      (wr_done),
        .busy         (busy),
        .finish       (finish)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;
    logic [31:0] rd_exp_q[$];   // {rd_offset, rd_addr}
    logic [31:0] wr_exp_q[$];   // {wr_addr, wr_data}
    logic [15:0] mem [0:65535];
    logic rand_dly = 1'b0;
    logic spurious = 1'b0;
    logic no_resp  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_rd(input int addr, input int off);
        rd_exp_q.push_back({16'(off), 16'(addr)});
    endtask

    task automatic push_wr(input int addr, input int data);
        wr_exp_q.push_back({16'(addr), 16'(data)});
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rd_req) begin
                if (rd_exp_q.size() == 0) check("unexpected_rd", {rd_offset, rd_addr}, 32'hFFFF_FFFF);
                else check("rd_addr_offset", {rd_offset, rd_addr}, rd_exp_q.pop_front());
            end
            if (wr_req) begin
                if (wr_exp_q.size() == 0) check("unexpected_wr", {wr_addr, wr_data}, 32'hFFFF_FFFF);
                else check("wr_addr_data", {wr_addr, wr_data}, wr_exp_q.pop_front());
            end
        end
    end

    // ---------------- DMA responder ----------------
    initial begin
        logic [15:0] a, o;
        int d;
        rd_done = 1'b0;
        wr_done = 1'b0;
        rd_data = '0;
        forever begin
            if (rd_req && !no_resp && !reset) begin
                a = rd_addr;
                o = rd_offset;
                d = rand_dly ? int'($urandom_range(1, 20)) : 1;
                repeat (d) @(negedge clk);
                for (int r = 0; r < 2; r++)
                    for (int c = 0; c < 2; c++)
                        rd_data[(r*2+c)*16 +: 16] = mem[16'(a + 16'(r) * o + 16'(c))];
                rd_done = 1'b1;
                @(negedge clk);
                rd_done = 1'b0;
            end else if (wr_req && !reset) begin
                d = rand_dly ? int'($urandom_range(1, 20)) : 1;
                if (spurious) begin
                    if (d < 3) d = 3;
                    @(negedge clk);
                    rd_done = 1'b1;          // stray pulse while in WR_WAIT
                    @(negedge clk);
                    rd_done = 1'b0;
                    d = d - 2;
                end
                repeat (d) @(negedge clk);
                wr_done = 1'b1;
                @(negedge clk);
                wr_done = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic run_layer(input string name, input int ch, input int sz, input int src,
                             input int dst, input logic mode, input int exp_lat);
        int lat;
        cfg_channels = 8'(ch);
        cfg_size     = 6'(sz);
        cfg_src_base = 16'(src);
        cfg_dst_base = 16'(dst);
        cfg_mode     = mode;
        start        = 1'b1;
        lat          = 1;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) begin
                // config must already be latched; scramble it
                cfg_channels = 8'($urandom_range(1, 100));
                cfg_size     = 6'($urandom_range(2, 32));
                cfg_src_base = 16'($urandom);
                cfg_dst_base = 16'($urandom);
                cfg_mode     = ~mode;
            end
        end while (!finish && lat < 5000);
        if (!finish) begin
            check({name, "_timeout"}, 32'(lat), 32'(exp_lat));
            rd_exp_q.delete();
            wr_exp_q.delete();
        end else if (exp_lat > 0) begin
            check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        end
        check({name, "_rd_left"}, 32'(rd_exp_q.size()), 32'd0);
        check({name, "_wr_left"}, 32'(wr_exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check({name, "_finish_hold"}, {31'd0, finish}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check({name, "_idle_after"}, {30'd0, finish, busy}, 32'd0);
    endtask

    task automatic expect_4x4(input logic mode);
        push_rd(100, 4); push_rd(102, 4); push_rd(108, 4); push_rd(110, 4);
        if (mode) begin
            push_wr(500, 2); push_wr(501, 4); push_wr(502, 10); push_wr(503, 12);
        end else begin
            push_wr(500, 5); push_wr(501, 7); push_wr(502, 13); push_wr(503, 15);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n, k;
        reset = 1'b1;
        start = 1'b0;
        cfg_channels = '0; cfg_size = '0; cfg_src_base = '0; cfg_dst_base = '0; cfg_mode = 1'b0;
        for (int i = 0; i < 16; i++)  mem[100 + i]  = 16'(i);
        for (int i = 0; i < 300; i++) mem[1000 + i] = 16'(i);
        mem[2000] = 16'hFFFF; mem[2001] = 16'hFFFE; mem[2002] = 16'hFFFE; mem[2003] = 16'hFFFE;
        mem[2100] = 16'h8000; mem[2101] = 16'h8000; mem[2102] = 16'h8000; mem[2103] = 16'h7FFF;
        for (int i = 0; i < 4; i++) mem[2200 + i] = 16'h8000;
        repeat (4) @(negedge clk);

        // reset state
        check("rst_rd_req",    {31'd0, rd_req}, 32'd0);
        check("rst_wr_req",    {31'd0, wr_req}, 32'd0);
        check("rst_busy",      {31'd0, busy},   32'd0);
        check("rst_finish",    {31'd0, finish}, 32'd0);
        check("rst_rd_addr",   {16'd0, rd_addr},   32'd0);
        check("rst_rd_offset", {16'd0, rd_offset}, 32'd0);
        check("rst_wr_addr",   {16'd0, wr_addr},   32'd0);
        check("rst_wr_data",   {16'd0, wr_data},   32'd0);
        reset = 1'b0;
        @(negedge clk);

        // 4x4 max and average, minimum-latency handshakes (5*4+2 cycles)
        expect_4x4(1'b0);
        run_layer("max4x4", 1, 4, 100, 500, 1'b0, 22);
        expect_4x4(1'b1);
        run_layer("avg4x4", 1, 4, 100, 500, 1'b1, 22);

        // single-window corner cases
        push_rd(2000, 2); push_wr(600, 16'hFFFE);
        run_layer("avg_floor", 1, 2, 2000, 600, 1'b1, 7);
        push_rd(2100, 2); push_wr(610, 16'h7FFF);
        run_layer("max_7fff", 1, 2, 2100, 610, 1'b0, 7);
        push_rd(2200, 2); push_wr(620, 16'h8000);
        run_layer("max_8000", 1, 2, 2200, 620, 1'b0, 7);

        // 3 channels of 10x10: out 5x5, 75 writes, channel 2 starts at src+200
        n = 0;
        for (int c = 0; c < 3; c++)
            for (int oy = 0; oy < 5; oy++)
                for (int ox = 0; ox < 5; ox++) begin
                    push_rd(1000 + c*100 + oy*20 + ox*2, 10);
                    push_wr(3000 + n, c*100 + (2*oy + 1)*10 + 2*ox + 1);
                    n++;
                end
        run_layer("ch3_size10", 3, 10, 1000, 3000, 1'b0, 377);

        // random handshake delays plus stray rd_done in WR_WAIT
        rand_dly = 1'b1;
        spurious = 1'b1;
        expect_4x4(1'b0);
        run_layer("max4x4_rand", 1, 4, 100, 500, 1'b0, 0);
        rand_dly = 1'b0;
        spurious = 1'b0;

        // degenerate layers: finish in the second cycle of start, no requests
        run_layer("zero_ch", 0, 4, 100, 500, 1'b0, 2);
        run_layer("small_size", 1, 1, 100, 500, 1'b0, 2);

        // reset while waiting for a window
        no_resp = 1'b1;
        push_rd(100, 4);
        cfg_channels = 8'd1; cfg_size = 6'd4; cfg_src_base = 16'd100;
        cfg_dst_base = 16'd500; cfg_mode = 1'b0;
        start = 1'b1;
        k = 0;
        while (!rd_req && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_rst_saw_rd", {31'd0, rd_req}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",   {31'd0, busy},   32'd0);
        check("mid_rst_finish", {31'd0, finish}, 32'd0);
        check("mid_rst_rd_req", {31'd0, rd_req}, 32'd0);
        check("mid_rst_wr_req", {31'd0, wr_req}, 32'd0);
        reset = 1'b0;
        no_resp = 1'b0;
        rd_exp_q.delete();
        @(negedge clk);
        expect_4x4(1'b0);
        run_layer("replay", 1, 4, 100, 500, 1'b0, 22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
